regmel_bank: RTL and testbench

Parametrised successor to the mel accumulation register file. It holds DEPTH words of WIDTH bits with independent write and read ports, a per-write overwrite/accumulate mode with saturation, and a hardware clear sweep that runs automatically after reset and on request. It sits between the mel adder and the downstream log/DCT stage. Unlike the previous block, read and write can happen in the same cycle, and read data carries a valid strobe.

---
 rtl/regmel_pkg.sv | 24 ++
 rtl/regmel_sat_add.sv | 24 ++
 rtl/regmel_bank.sv | 151 +++++++++++++++
 tb/tb_regmel_bank.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regmel_pkg.sv
// -----------------------------------------------------------------------------
// regmel_pkg
// Shared types and constants for the mel accumulation register bank.
//   regmel_state_e : clear-sweep FSM states (ST_IDLE, ST_CLEAR)
//   REGMEL_WIDTH   : default data word width
//   REGMEL_DEPTH   : default number of words
//   regmel_aw()    : address width needed to index a given depth
// -----------------------------------------------------------------------------
package regmel_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } regmel_state_e;

   localparam int REGMEL_WIDTH = 44;
   localparam int REGMEL_DEPTH = 23;

   // Address width for a bank of the given depth (at least one bit).
   function automatic int regmel_aw(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/regmel_sat_add.sv
// -----------------------------------------------------------------------------
// regmel_sat_add
// Combinational unsigned saturating adder.
//   a, b : WIDTH-bit unsigned operands
//   sum  : a + b, clamped to all-ones on overflow
//   sat  : high when the addition overflowed and sum was clamped
// -----------------------------------------------------------------------------
module regmel_sat_add #(
   parameter int WIDTH = 44
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             sat
);

   logic [WIDTH:0] sum_full;

   // One extra bit captures the carry that signals overflow.
   assign sum_full = {1'b0, a} + {1'b0, b};
   assign sat      = sum_full[WIDTH];
   assign sum      = sum_full[WIDTH] ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];

endmodule

// File: rtl/regmel_bank.sv
// -----------------------------------------------------------------------------
// regmel_bank
// DEPTH x WIDTH accumulation register bank with independent write and read
// ports, overwrite/accumulate writes with saturation, and a hardware clear
// sweep that runs after reset and on request.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : pulse that (re)starts a clear sweep; also clears sat_flag
//   busy       : high while the clear sweep runs; accesses are ignored then
//   wr_en, wr_acc, wr_addr, wr_data : write port (wr_acc=1 accumulates)
//   rd_en, rd_addr                  : read request
//   rd_data, rd_valid               : registered read result and strobe
//   sat_flag   : sticky, set when an accumulate saturated
// -----------------------------------------------------------------------------
module regmel_bank
   import regmel_pkg::*;
#(
   parameter int WIDTH = REGMEL_WIDTH,
   parameter int DEPTH = REGMEL_DEPTH,
   parameter int AW    = regmel_aw(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   output logic             busy,
   input  logic             wr_en,
   input  logic             wr_acc,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             sat_flag
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

   regmel_state_e    state_reg, state_next;
   logic [AW-1:0]    clr_addr_reg, clr_addr_next;
   logic [WIDTH-1:0] rd_data_reg, rd_data_next;
   logic             rd_valid_reg, rd_valid_next;
   logic             sat_flag_reg, sat_flag_next;

   logic [WIDTH-1:0] mem [DEPTH];

   logic             wr_in_range;
   logic             rd_in_range;
   logic             wr_fire;
   logic [WIDTH-1:0] wr_old;
   logic [WIDTH-1:0] acc_sum;
   logic             acc_sat;
   logic [WIDTH-1:0] wr_value;

   assign busy = (state_reg == ST_CLEAR);

   // Addresses at or beyond DEPTH are legal on the ports (DEPTH need not be a
   // power of two) but never touch the array.
   assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
   assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
   assign wr_fire     = wr_en && !busy && wr_in_range;

   // Read-modify-write completes in one cycle, so consecutive accumulates to
   // the same word always see the previous result without forwarding.
   assign wr_old = wr_in_range ? mem[wr_addr] : '0;

   regmel_sat_add #(
      .WIDTH (WIDTH)
   ) u_sat_add (
      .a   (wr_old),
      .b   (wr_data),
      .sum (acc_sum),
      .sat (acc_sat)
   );

   assign wr_value = wr_acc ? acc_sum : wr_data;

   // ---------------- clear-sweep FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_CLEAR;
         clr_addr_reg <= '0;
      end else begin
         state_reg    <= state_next;
         clr_addr_reg <= clr_addr_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      clr_addr_next = clr_addr_reg;
      if (clr) begin
         // A request mid-sweep simply restarts from word 0.
         state_next    = ST_CLEAR;
         clr_addr_next = '0;
      end else if (state_reg == ST_CLEAR) begin
         if (clr_addr_reg == LAST_ADDR) begin
            state_next    = ST_IDLE;
            clr_addr_next = '0;
         end else begin
            clr_addr_next = clr_addr_reg + 1'b1;
         end
      end
   end

   // ---------------- storage ----------------
   // Not reset: the sweep that follows every reset zeroes the contents.
   always_ff @(posedge clk) begin
      if (state_reg == ST_CLEAR) begin
         mem[clr_addr_reg] <= '0;
      end else if (wr_fire) begin
         mem[wr_addr] <= wr_value;
      end
   end

   // ---------------- read port and sticky flag ----------------
   always_comb begin
      rd_data_next  = rd_data_reg;
      rd_valid_next = 1'b0;
      if (rd_en && !busy) begin
         rd_valid_next = 1'b1;
         rd_data_next  = rd_in_range ? mem[rd_addr] : '0;
      end
   end

   always_comb begin
      sat_flag_next = sat_flag_reg;
      if (clr) begin
         sat_flag_next = 1'b0;
      end else if (wr_fire && wr_acc && acc_sat) begin
         sat_flag_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
         sat_flag_reg <= 1'b0;
      end else begin
         rd_data_reg  <= rd_data_next;
         rd_valid_reg <= rd_valid_next;
         sat_flag_reg <= sat_flag_next;
      end
   end

   assign rd_data  = rd_data_reg;
   assign rd_valid = rd_valid_reg;
   assign sat_flag = sat_flag_reg;

endmodule

// File: tb/tb_regmel_bank.sv
// -----------------------------------------------------------------------------
// tb_regmel_bank
// Scoreboard bench for regmel_bank: reads push their expected data into a
// queue, and a monitor pops and compares whenever rd_valid is presented.
// -----------------------------------------------------------------------------
module tb_regmel_bank;
   import regmel_pkg::*;

   localparam int WIDTH = 44;
   localparam int DEPTH = 23;
   localparam int AW    = 5;
   localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

   logic             clk;
   logic             rst_n;
   logic             clr;
   logic             busy;
   logic             wr_en;
   logic             wr_acc;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             rd_en;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             sat_flag;

   typedef struct {
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] data;
   } exp_t;

   exp_t             exp_q[$];
   logic [WIDTH-1:0] model [DEPTH];
   int               checks;
   int               errors;
   int               rd_count;
   int               n;

   regmel_bank #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .busy     (busy),
      .wr_en    (wr_en),
      .wr_acc   (wr_acc),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .sat_flag (sat_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n && rd_valid) begin
         exp_t e;
         checks++;
         rd_count++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: rd_valid=1 data=%h, no read outstanding", rd_data);
         end else begin
            e = exp_q.pop_front();
            if (rd_data !== e.data) begin
               errors++;
               $display("FAIL rd_data addr=%0d: got %h, expected %h", e.addr, rd_data, e.data);
            end else begin
               $display("read #%0d addr=%0d data=%h ok", rd_count, e.addr, rd_data);
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         $display("check %s = %h ok", name, act);
      end
   endtask

   task automatic push_exp(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      exp_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic issue_read(input logic [AW-1:0] a);
      logic [WIDTH-1:0] d;
      d = '0;
      if (int'(a) < DEPTH) d = model[a];
      rd_en   = 1'b1;
      rd_addr = a;
      push_exp(a, d);
      cyc();
      rd_en = 1'b0;
   endtask

   task automatic issue_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                              input logic acc, input logic [WIDTH-1:0] exp_word);
      wr_en   = 1'b1;
      wr_acc  = acc;
      wr_addr = a;
      wr_data = d;
      cyc();
      wr_en  = 1'b0;
      wr_acc = 1'b0;
      if (int'(a) < DEPTH) model[a] = exp_word;
   endtask

   task automatic read_all();
      for (int i = 0; i < DEPTH; i++) issue_read(AW'(i));
   endtask

   task automatic wait_sweep(output int cnt);
      cnt = 0;
      while (busy && cnt < 100) begin
         cyc();
         cnt++;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      checks   = 0;
      errors   = 0;
      rd_count = 0;
      rst_n    = 1'b0;
      clr      = 1'b0;
      wr_en    = 1'b0;
      wr_acc   = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      rd_en    = 1'b0;
      rd_addr  = '0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;

      // Reset values
      cyc();
      cyc();
      check("reset_busy", 64'(busy), 64'd1);
      check("reset_rd_valid", 64'(rd_valid), 64'd0);
      check("reset_rd_data", 64'(rd_data), 64'd0);
      check("reset_sat_flag", 64'(sat_flag), 64'd0);

      // Sweep after reset release lasts exactly DEPTH cycles
      rst_n = 1'b1;
      wait_sweep(n);
      check("reset_sweep_len", 64'(n), 64'd23);
      read_all();

      // Overwrite then read
      issue_write(5'd5, 44'h123, 1'b0, 44'h123);
      issue_read(5'd5);

      // Same-cycle write and read: read sees the pre-write value
      issue_write(5'd3, 44'h11, 1'b0, 44'h11);
      wr_en   = 1'b1;
      wr_acc  = 1'b0;
      wr_addr = 5'd3;
      wr_data = 44'hAA;
      rd_en   = 1'b1;
      rd_addr = 5'd3;
      push_exp(5'd3, 44'h11);
      cyc();
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      model[3] = 44'hAA;
      issue_read(5'd3);

      // Non-saturating accumulate: 0x123 + 0x100
      issue_write(5'd5, 44'h100, 1'b1, 44'h223);
      check("sat_flag_no_sat", 64'(sat_flag), 64'd0);
      issue_read(5'd5);

      // Back-to-back accumulates to one address
      issue_write(5'd9, 44'h5, 1'b1, 44'h5);
      issue_write(5'd9, 44'h7, 1'b1, 44'hC);
      issue_read(5'd9);

      // Saturation
      issue_write(5'd7, 44'hFFF_FFFF_FFF0, 1'b0, 44'hFFF_FFFF_FFF0);
      issue_write(5'd7, 44'h10, 1'b1, ONES);
      check("sat_flag_set", 64'(sat_flag), 64'd1);
      issue_read(5'd7);
      issue_write(5'd7, 44'h1, 1'b1, ONES);
      issue_read(5'd7);
      check("sat_flag_sticky", 64'(sat_flag), 64'd1);

      // Out-of-range write dropped, out-of-range read returns 0
      issue_write(5'd25, 44'hDEAD, 1'b0, '0);
      read_all();
      issue_read(5'd25);

      // Clear request, accesses while busy are ignored
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      check("clr_sat_flag", 64'(sat_flag), 64'd0);
      check("clr_busy", 64'(busy), 64'd1);
      wr_en   = 1'b1;
      wr_acc  = 1'b0;
      wr_addr = 5'd7;
      wr_data = 44'h55;
      rd_en   = 1'b1;
      rd_addr = 5'd7;
      for (int i = 0; i < 9; i++) cyc();
      // Second pulse at sweep step 10 restarts the sweep
      clr = 1'b1;
      cyc();
      clr     = 1'b0;
      wr_addr = 5'd0;
      wr_data = 44'h77;
      rd_addr = 5'd1;
      wait_sweep(n);
      wr_en = 1'b0;
      rd_en = 1'b0;
      check("clr_sweep_len", 64'(n), 64'd23);
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      read_all();

      cyc();
      cyc();
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
